// File: rtl/bnn_param_loader.sv
// Loads the binary-neuron array's serial parameter chain from host bytes.
// Bytes are shifted MSB-first and setup_o is high only on cycles that carry a
// chain bit. After the last bit a settle window runs, then run_valid is raised.
module bnn_param_loader #(
    parameter int CHAIN_BITS    = 128,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              abort,
    input  logic [7:0]                        byte_data,
    input  logic                              byte_valid,
    output logic                              byte_ready,
    output logic                              setup_o,
    output logic                              param_o,
    output logic                              busy,
    output logic                              run_valid,
    output logic [$clog2(CHAIN_BITS+1)-1:0]   bits_left
);

    localparam int LW = $clog2(CHAIN_BITS + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} state_t;

    state_t        state, state_n;
    logic [7:0]    shreg, shreg_n;
    logic [3:0]    pend, pend_n;
    logic [LW-1:0] left_n;
    logic [SW-1:0] settle_cnt, settle_n;
    logic          setup_n, param_n, ready_n, busy_n, run_n;
    logic          hs;

    assign hs = byte_valid && byte_ready;

    // Next-state and next-output computation; all outputs are registered.
    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        pend_n   = pend;
        left_n   = bits_left;
        settle_n = settle_cnt;
        setup_n  = 1'b0;
        param_n  = 1'b0;
        unique case (state)
            IDLE, RUN: begin
                if (start) begin
                    state_n  = LOAD;
                    left_n   = LW'(CHAIN_BITS);
                    pend_n   = '0;
                    settle_n = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_n = IDLE;
                    left_n  = LW'(CHAIN_BITS);
                    pend_n  = '0;
                end else begin
                    // Emit the next pending bit; a byte accepted on the same
                    // edge replaces the shifter so streaming stays gapless.
                    if (pend != '0) begin
                        setup_n = 1'b1;
                        param_n = shreg[7];
                        shreg_n = {shreg[6:0], 1'b0};
                        pend_n  = pend - 4'd1;
                        if (bits_left != '0)
                            left_n = bits_left - LW'(1);
                    end
                    if (hs) begin
                        shreg_n = byte_data;
                        pend_n  = 4'd8;
                    end
                    if (left_n == '0) begin
                        state_n  = SETTLE;
                        settle_n = '0;
                    end
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_n = IDLE;
                    left_n  = LW'(CHAIN_BITS);
                    pend_n  = '0;
                end else if (settle_cnt == SW'(SETTLE_CYCLES)) begin
                    state_n = RUN;
                end else begin
                    settle_n = settle_cnt + SW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        ready_n = (state_n == LOAD) &&
                  ((pend_n == '0) || ((pend_n == 4'd1) && (left_n > LW'(1))));
        busy_n  = (state_n == LOAD) || (state_n == SETTLE);
        run_n   = (state_n == RUN);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            pend       <= '0;
            settle_cnt <= '0;
            bits_left  <= LW'(CHAIN_BITS);
            byte_ready <= 1'b0;
            setup_o    <= 1'b0;
            param_o    <= 1'b0;
            busy       <= 1'b0;
            run_valid  <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            pend       <= pend_n;
            settle_cnt <= settle_n;
            bits_left  <= left_n;
            byte_ready <= ready_n;
            setup_o    <= setup_n;
            param_o    <= param_n;
            busy       <= busy_n;
            run_valid  <= run_n;
        end
    end

endmodule

// File: doc/bnn_param_loader.md
Name: bnn_param_loader

Overview:
- Sequences configuration of the binary-neuron array's serial parameter chain.
- Accepts parameter bytes from a host over a valid/ready handshake and serializes them MSB-first onto the chain head. Drives the array's setup strobe only on cycles where a valid bit is presented, so host stalls never shift garbage into the chain.
- After the final bit, waits a settle window, then signals that the array is configured and inference outputs are valid.

Parameters:
- CHAIN_BITS, 128, total parameter bits in the chain; must be a multiple of 8 and at least 8.
- SETTLE_CYCLES, 2, cycles with setup low after the last bit before run_valid rises; at least 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
- start  input  1  begin a load; honoured only in IDLE or RUN.
- abort  input  1  cancel a load in progress; honoured in LOAD and SETTLE.
- byte_data  input  8  parameter byte; bit 7 is shifted first.
- byte_valid  input  1  byte_data is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- setup_o  output  1  array setup strobe; high exactly on cycles where param_o carries a chain bit.
- param_o  output  1  serial bit to the chain head.
- busy  output  1  high in LOAD and SETTLE.
- run_valid  output  1  high in RUN: array is fully configured.
- bits_left  output  $clog2(CHAIN_BITS+1)  chain bits not yet shifted.

Behaviour:
- Outputs are registered.
- Reset values: state IDLE, byte_ready=0, setup_o=0, param_o=0, busy=0, run_valid=0, bits_left=CHAIN_BITS. Reset dominates every other input, including mid-load; the chain contents are then undefined and only a new start recovers them.
- States: IDLE, LOAD, SETTLE, RUN.
- IDLE: on start, go to LOAD and set bits_left=CHAIN_BITS.
- LOAD: busy=1.
  - byte_ready=1 when no byte is pending, or when the pending byte is on its 8th bit and bits_left>1 after that bit.
  - A handshake (byte_valid && byte_ready) at edge t captures the byte. On edges t+1..t+8, setup_o=1 and param_o=byte[7],byte[6],…,byte[0].
  - A handshake on the last-bit cycle makes streaming gapless.
  - bits_left decrements by 1 for each cycle setup_o=1.
  - A cycle with no pending bits gives setup_o=0 and param_o=0; the chain holds.
- LOAD→SETTLE on the edge after the last bit, when bits_left reaches 0. byte_ready is 0 on the final bit cycle; no extra byte is consumed.
- SETTLE: setup_o=0 and busy=1. Count SETTLE_CYCLES cycles, then go to RUN.
- RUN: run_valid=1, busy=0, setup_o=0. start goes to LOAD; run_valid drops on the same edge.
- abort in LOAD or SETTLE: go to IDLE on the next edge.
  - setup_o=0 on that edge; any pending byte is discarded; bits_left=CHAIN_BITS.
  - abort wins over a simultaneous handshake.
- start while busy: ignored.
- start in IDLE or RUN together with abort: start wins; abort is meaningless there.
- byte_valid outside LOAD: ignored; byte_ready=0.
- bits_left never underflows; it saturates at 0.

Test Plan:
- Reset, then idle 5 cycles -> byte_ready=0, setup_o=0, busy=0, run_valid=0, bits_left=128.
- CHAIN_BITS=16. start; bytes 0xA5 then 0x3C, valid held high -> 16 consecutive setup_o=1 cycles with param_o=1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0. Then 2 cycles setup_o=0, busy=1, then run_valid=1. Exactly 2 handshakes.
- CHAIN_BITS=16. Present 0xFF; host drops byte_valid 3 cycles, then presents 0x00 -> 8 ones, then 3 cycles setup_o=0 with bits_left held at 8, then 8 zeros. Total setup_o-high cycles=16.
- abort asserted together with a handshake after 5 bits of the first byte -> next edge: IDLE, setup_o=0, bits_left=CHAIN_BITS. A new start reloads from bit 0.
- start in RUN -> run_valid falls on the next edge and a full reload of CHAIN_BITS bits follows. start pulsed mid-LOAD -> no effect on bits_left.
- rst_n low for 1 cycle mid-LOAD and mid-SETTLE -> all outputs return to reset values on the next edge. A byte offered afterwards is not accepted until start.
